// File: rtl/y_demux_pkg.sv
// Shared types and default sizes for the two-channel TDM demultiplexer.
package y_demux_pkg;

  localparam int unsigned DEF_WIDTH = 2;
  localparam int unsigned DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    EXP_A = 2'd0,
    EXP_B = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/y_demux2_tdm.sv
// Splits an interleaved A,B,A,B word stream into held A/B pairs with a delivered-pair counter.
// Optional sync_err pulse on B-slot resync is enabled by defining Y_DEMUX2_SYNC_ERR_EN.
module y_demux2_tdm
  import y_demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sync,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] pair_cnt
`ifdef Y_DEMUX2_SYNC_ERR_EN
  ,
  output logic             sync_err
`endif
);

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   a_nxt;
  logic [WIDTH-1:0]   b_nxt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               accept;
`ifdef Y_DEMUX2_SYNC_ERR_EN
  logic               sync_ev;
`endif

  // Handshake flags decode directly from the state register.
  assign in_ready  = (state != FULL);
  assign out_valid = (state == FULL);
  assign accept    = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EXP_A;
      a_out    <= '0;
      b_out    <= '0;
      pair_cnt <= '0;
`ifdef Y_DEMUX2_SYNC_ERR_EN
      sync_err <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      a_out    <= a_nxt;
      b_out    <= b_nxt;
      pair_cnt <= cnt_nxt;
`ifdef Y_DEMUX2_SYNC_ERR_EN
      sync_err <= sync_ev;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    a_nxt     = a_out;
    b_nxt     = b_out;
    cnt_nxt   = pair_cnt;
`ifdef Y_DEMUX2_SYNC_ERR_EN
    sync_ev   = 1'b0;
`endif
    unique case (state)
      EXP_A: begin
        if (accept) begin
          a_nxt     = in_data;
          state_nxt = EXP_B;
        end
      end
      EXP_B: begin
        // A sync marker in the B slot restarts the frame with this beat as the new A.
        if (accept) begin
          if (in_sync) begin
            a_nxt = in_data;
`ifdef Y_DEMUX2_SYNC_ERR_EN
            sync_ev = 1'b1;
`endif
          end else begin
            b_nxt     = in_data;
            state_nxt = FULL;
          end
        end
      end
      FULL: begin
        if (out_ready) begin
          cnt_nxt   = pair_cnt + CNT_W'(1);
          state_nxt = EXP_A;
        end
      end
      default: state_nxt = EXP_A;
    endcase
  end

endmodule

// File: tb/tb_y_demux2_tdm.sv
// Directed bench for y_demux2_tdm; sync_err checks follow Y_DEMUX2_SYNC_ERR_EN.
module tb_y_demux2_tdm;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_data;
  logic       in_sync;
  logic [1:0] a_out;
  logic [1:0] b_out;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] pair_cnt;
`ifdef Y_DEMUX2_SYNC_ERR_EN
  logic       sync_err;
`endif

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_cnt;

  y_demux2_tdm #(.WIDTH(2), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sync   (in_sync),
    .a_out     (a_out),
    .b_out     (b_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pair_cnt  (pair_cnt)
`ifdef Y_DEMUX2_SYNC_ERR_EN
    ,
    .sync_err  (sync_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock, then settle past the edge before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [1:0] d, input logic s);
    in_valid = 1'b1;
    in_data  = d;
    in_sync  = s;
    tick();
    in_valid = 1'b0;
    in_sync  = 1'b0;
  endtask

  task automatic deliver();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_cnt   = exp_cnt + 8'd1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 2'b00; in_sync = 1'b0; out_ready = 1'b0;
    exp_cnt = 8'd0;
    #2;
    checks++; if (a_out !== 2'b00) begin failures++; $display("FAIL reset_a got=%0h exp=0", a_out); end
    checks++; if (b_out !== 2'b00) begin failures++; $display("FAIL reset_b got=%0h exp=0", b_out); end
    checks++; if (pair_cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", pair_cnt); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_ovalid got=%0b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_iready got=%0b exp=1", in_ready); end
`ifdef Y_DEMUX2_SYNC_ERR_EN
    checks++; if (sync_err !== 1'b0) begin failures++; $display("FAIL reset_syncerr got=%0b exp=0", sync_err); end
`endif
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_hold_full();
    send_beat(2'b01, 1'b0);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL hold_after_a_ovalid got=%0b exp=0", out_valid); end
    send_beat(2'b10, 1'b0);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL hold_latency_ovalid got=%0b exp=1", out_valid); end
    // Offer conflicting beats and out_ready low; nothing may move.
    in_valid = 1'b1; in_data = 2'b11; in_sync = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || a_out !== 2'b01 || b_out !== 2'b10)
        begin failures++; $display("FAIL hold_cyc%0d got rdy=%0b vld=%0b a=%0h b=%0h exp rdy=0 vld=1 a=1 b=2", i, in_ready, out_valid, a_out, b_out); end
    end
    in_valid = 1'b0; in_sync = 1'b0;
    checks++; if (pair_cnt !== 8'd0) begin failures++; $display("FAIL hold_cnt got=%0d exp=0", pair_cnt); end
  endtask

  task automatic test_deliver();
    deliver();
    checks++; if (pair_cnt !== 8'd1) begin failures++; $display("FAIL deliver_cnt got=%0d exp=1", pair_cnt); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL deliver_ovalid got=%0b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL deliver_iready got=%0b exp=1", in_ready); end
    // out_ready outside FULL is ignored.
    out_ready = 1'b1; tick(); tick(); out_ready = 1'b0;
    checks++; if (pair_cnt !== 8'd1) begin failures++; $display("FAIL idle_ready_cnt got=%0d exp=1", pair_cnt); end
  endtask

  task automatic test_resync();
    send_beat(2'b11, 1'b1);
    checks++; if (a_out !== 2'b11) begin failures++; $display("FAIL resync_a1 got=%0h exp=3", a_out); end
    // Sync without a valid beat must be ignored.
    in_sync = 1'b1; in_data = 2'b10; tick(); in_sync = 1'b0;
    checks++; if (a_out !== 2'b11 || out_valid !== 1'b0) begin failures++; $display("FAIL resync_idle got a=%0h vld=%0b exp a=3 vld=0", a_out, out_valid); end
    send_beat(2'b00, 1'b1);
    checks++; if (a_out !== 2'b00 || out_valid !== 1'b0 || in_ready !== 1'b1)
      begin failures++; $display("FAIL resync_newa got a=%0h vld=%0b rdy=%0b exp a=0 vld=0 rdy=1", a_out, out_valid, in_ready); end
`ifdef Y_DEMUX2_SYNC_ERR_EN
    checks++; if (sync_err !== 1'b1) begin failures++; $display("FAIL resync_err_on got=%0b exp=1", sync_err); end
`endif
    send_beat(2'b01, 1'b0);
`ifdef Y_DEMUX2_SYNC_ERR_EN
    checks++; if (sync_err !== 1'b0) begin failures++; $display("FAIL resync_err_off got=%0b exp=0", sync_err); end
`endif
    checks++; if (out_valid !== 1'b1 || a_out !== 2'b00 || b_out !== 2'b01)
      begin failures++; $display("FAIL resync_pair got vld=%0b a=%0h b=%0h exp vld=1 a=0 b=1", out_valid, a_out, b_out); end
    deliver();
    checks++; if (pair_cnt !== exp_cnt) begin failures++; $display("FAIL resync_cnt got=%0d exp=%0d", pair_cnt, exp_cnt); end
  endtask

  task automatic test_wrap();
    rst_n = 1'b0; #2; rst_n = 1'b1; tick();
    exp_cnt = 8'd0;
    out_ready = 1'b1;
    for (int p = 0; p < 256; p++) begin
      send_beat(2'(p), 1'b0);
      send_beat(2'(p + 1), 1'b0);
      tick();
      exp_cnt = exp_cnt + 8'd1;
      if (p == 254) begin
        checks++; if (pair_cnt !== 8'd255) begin failures++; $display("FAIL wrap_255 got=%0d exp=255", pair_cnt); end
      end
    end
    out_ready = 1'b0;
    checks++; if (pair_cnt !== 8'd0) begin failures++; $display("FAIL wrap_zero got=%0d exp=0", pair_cnt); end
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || a_out !== 2'b11 || b_out !== 2'b00)
      begin failures++; $display("FAIL wrap_side got vld=%0b rdy=%0b a=%0h b=%0h exp vld=0 rdy=1 a=3 b=0", out_valid, in_ready, a_out, b_out); end
  endtask

  task automatic test_async_reset();
    send_beat(2'b11, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (a_out !== 2'b00 || pair_cnt !== 8'd0 || out_valid !== 1'b0 || in_ready !== 1'b1)
      begin failures++; $display("FAIL areset_b got a=%0h cnt=%0d vld=%0b rdy=%0b exp a=0 cnt=0 vld=0 rdy=1", a_out, pair_cnt, out_valid, in_ready); end
    tick(); rst_n = 1'b1; tick();
    exp_cnt = 8'd0;
    send_beat(2'b10, 1'b0);
    send_beat(2'b01, 1'b0);
    checks++; if (a_out !== 2'b10 || b_out !== 2'b01 || out_valid !== 1'b1)
      begin failures++; $display("FAIL areset_pair got a=%0h b=%0h vld=%0b exp a=2 b=1 vld=1", a_out, b_out, out_valid); end
    deliver();
    checks++; if (pair_cnt !== 8'd1) begin failures++; $display("FAIL areset_cnt got=%0d exp=1", pair_cnt); end
    // Reset while a pair is held drops it without counting.
    send_beat(2'b01, 1'b0);
    send_beat(2'b11, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || pair_cnt !== 8'd0 || b_out !== 2'b00)
      begin failures++; $display("FAIL areset_full got vld=%0b cnt=%0d b=%0h exp vld=0 cnt=0 b=0", out_valid, pair_cnt, b_out); end
    tick(); rst_n = 1'b1; tick();
    exp_cnt = 8'd0;
  endtask

  task automatic test_sweep();
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        send_beat(2'(a), 1'b0);
        for (int g = 0; g < (a + b) % 3; g++) tick();
        send_beat(2'(b), 1'b0);
        checks++; if (out_valid !== 1'b1 || a_out !== 2'(a) || b_out !== 2'(b))
          begin failures++; $display("FAIL sweep_pair a=%0d b=%0d got vld=%0b a=%0h b=%0h", a, b, out_valid, a_out, b_out); end
        deliver();
        checks++; if (pair_cnt !== exp_cnt)
          begin failures++; $display("FAIL sweep_cnt a=%0d b=%0d got=%0d exp=%0d", a, b, pair_cnt, exp_cnt); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_hold_full();
    test_deliver();
    test_resync();
    test_wrap();
    test_async_reset();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/y_demux2_tdm.md
Y_DEMUX2_TDM -- requirements
Module: y_demux2_tdm

Interface
REQ-001 Parameter WIDTH, default 2: bit width of each channel word.
REQ-002 Parameter CNT_W, default 8: width of the delivered-pair counter.
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port in_valid  input  1  input beat present.
REQ-006 Port in_ready  output  1  block accepts a beat this cycle.
REQ-007 Port in_data  input  WIDTH  interleaved channel word: A, B, A, B, ...
REQ-008 Port in_sync  input  1  marks the current beat as channel A (frame start).
REQ-009 Port a_out  output  WIDTH  channel A word of the held pair.
REQ-010 Port b_out  output  WIDTH  channel B word of the held pair.
REQ-011 Port out_valid  output  1  a complete A/B pair is held.
REQ-012 Port out_ready  input  1  consumer takes the pair.
REQ-013 Port pair_cnt  output  CNT_W  count of pairs delivered.
REQ-014 Port sync_err  output  1  present only under Y_DEMUX2_SYNC_ERR_EN.

Function
REQ-015 A beat SHALL be accepted when in_valid and in_ready are both 1 on a rising edge.
REQ-016 FSM states SHALL be EXP_A, EXP_B and FULL.
REQ-017 In EXP_A: accepted beat -> a_out <= in_data; next state EXP_B.
REQ-018 In EXP_B: accepted beat with in_sync=0 -> b_out <= in_data; next state FULL.
REQ-019 In EXP_B: accepted beat with in_sync=1 -> treated as a new A (a_out <= in_data, stay in EXP_B); the earlier A is discarded.
REQ-020 In EXP_A, in_sync SHALL have no extra effect; in_sync without an accepted beat SHALL be ignored.
REQ-021 in_ready SHALL be 1 in EXP_A and EXP_B, and 0 in FULL (combinational from state only).
REQ-022 out_valid SHALL be 1 exactly in FULL; a_out and b_out SHALL be stable while out_valid=1.
REQ-023 In FULL with out_ready=1: pair delivered; pair_cnt increments by 1; next state EXP_A.
REQ-024 In FULL with out_ready=0: the block SHALL hold its state indefinitely.
REQ-025 Latency SHALL be one cycle: B accepted at edge N gives out_valid=1 after edge N.
REQ-026 Pair throughput SHALL be at most one pair per 3 cycles.
REQ-027 pair_cnt SHALL wrap from 2^CNT_W-1 to 0 without a flag.
REQ-028 out_ready while not in FULL SHALL have no effect.

Reset
REQ-029 rst_n=0 SHALL, immediately and regardless of clk, set state EXP_A, a_out=0, b_out=0, pair_cnt=0 and sync_err=0.
REQ-030 Under reset, out_valid SHALL be 0 and in_ready SHALL be 1.
REQ-031 Reset mid-frame or mid-FULL SHALL discard the partial or held pair, with no delivery and no count.

Configuration
REQ-032 Macro Y_DEMUX2_SYNC_ERR_EN SHALL control the sync_err port.
REQ-033 With the macro defined: sync_err pulses 1 for one cycle after each REQ-019 event.
REQ-034 Without the macro: the sync_err port and its logic are absent; REQ-019 behaviour is unchanged.

Structure
REQ-035 Package y_demux_pkg SHALL hold the FSM state enum (EXP_A, EXP_B, FULL) and the default WIDTH and CNT_W constants.
REQ-036 The design SHALL be a single module; no sub-module.

Verification
REQ-037 Reset then A=2'b01, B=2'b10 on consecutive cycles, out_ready=0 -> out_valid=1 with a_out=01, b_out=10; in_ready=0 held for 5 cycles.
REQ-038 From REQ-037, raise out_ready for one cycle -> pair_cnt=1; state EXP_A; in_ready=1 on the next cycle.
REQ-039 A=11, then B-slot beat 00 with in_sync=1, then 01 -> delivered pair a_out=00, b_out=01; sync_err pulses once (macro on).
REQ-040 Deliver 256 pairs with out_ready=1 -> pair_cnt returns to 0 with no other side effect.
REQ-041 Assert rst_n=0 mid-cycle while in EXP_B -> outputs clear asynchronously; the next A/B pair delivers normally with pair_cnt=1.
REQ-042 Exhaustive sweep of all 16 A/B value combinations with in_valid gaps -> every delivered pair matches its inputs; PASS/FAIL reported per pair.
